// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the PC, issues word reads over a
// req/ack handshake, captures the returned word into the MDR and strobes
// IR_load so the instruction register latches it. Redirects issued while a
// read is outstanding mark that read as killed so its data is dropped.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] MDR_data,
  output logic              IR_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_inc_d;
  logic [DATA_W-1:0]   mdr_q;
  logic                ir_load_q;
  logic                kill_q;

  // Sequential next PC after a completed fetch; wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_inc_d = pc_q + ADDR_W'(1);
  end

  // Fetch FSM. IR_load is registered and asserted exactly while in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      mdr_q     <= '0;
      ir_load_q <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      ir_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A redirect here lands before the first request cycle.
          if (pc_load)  pc_q    <= pc_load_addr;
          if (fetch_en) state_q <= REQ;
        end
        REQ: begin
          if (mem_rd_ack) begin
            if (kill_q || pc_load) begin
              // Stale word: drop it and return to IDLE without a load strobe.
              kill_q  <= 1'b0;
              state_q <= IDLE;
              if (pc_load) pc_q <= pc_load_addr;
            end else begin
              mdr_q     <= mem_rd_data;
              ir_load_q <= 1'b1;
              state_q   <= LOAD;
            end
          end else if (pc_load) begin
            // Request stays up at the new address; its eventual data is stale.
            pc_q   <= pc_load_addr;
            kill_q <= 1'b1;
          end
        end
        LOAD: begin
          pc_q    <= pc_load ? pc_load_addr : pc_inc_d;
          state_q <= fetch_en ? REQ : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr   = pc_q;
  assign pc_out     = pc_q;
  assign mem_rd_req = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign MDR_data   = mdr_q;
  assign IR_load    = ir_load_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for wait-state fetching and reset during an outstanding read.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;
  logic [15:0] MDR_data;
  logic        IR_load;
  logic [15:0] pc_out;
  logic        busy;

  int npass = 0;
  int ntot  = 0;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .MDR_data(MDR_data),
    .IR_load(IR_load), .pc_out(pc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fe, pl;
    logic [15:0] pla;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req, e_busy, e_ir;
    logic [15:0] e_mdr, e_pc;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic fe, input logic pl, input logic [15:0] pla,
                       input logic ack, input logic [15:0] rd);
    reset = r; fetch_en = fe; pc_load = pl; pc_load_addr = pla;
    mem_rd_ack = ack; mem_rd_data = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rst, logic fe, logic pl, logic [15:0] pla, logic ack,
                              logic [15:0] rd, logic req, logic bsy, logic ir,
                              logic [15:0] mdr, logic [15:0] pc);
    vec_t t;
    t.rst = rst; t.fe = fe; t.pl = pl; t.pla = pla; t.ack = ack; t.rdata = rd;
    t.e_req = req; t.e_busy = bsy; t.e_ir = ir; t.e_mdr = mdr; t.e_pc = pc;
    return t;
  endfunction

  initial begin
    int ir_cnt, ir_first, ir_second, wcnt;
    logic [15:0] req_addr;
    logic stable;

    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

    // rst fe pl pla ack rdata | req busy ir mdr pc  (expected after the edge)
    v.push_back(mk(1,0,0,16'h0000,0,16'h0000, 0,0,0,16'h0000,16'h0000)); // reset state
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h0000,16'h0000)); // IDLE->REQ
    v.push_back(mk(0,0,0,16'h0000,1,16'hA5C3, 0,1,1,16'hA5C3,16'h0000)); // ack -> LOAD
    v.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,0,0,16'hA5C3,16'h0001)); // pc+1
    v.push_back(mk(0,1,1,16'hFFFF,0,16'h0000, 1,1,0,16'hA5C3,16'hFFFF)); // redirect in IDLE + fetch
    v.push_back(mk(0,0,0,16'h0000,1,16'h1234, 0,1,1,16'h1234,16'hFFFF));
    v.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,0,0,16'h1234,16'h0000)); // wrap
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h1234,16'h0000));
    v.push_back(mk(0,0,1,16'h0040,0,16'h0000, 1,1,0,16'h1234,16'h0040)); // redirect in REQ
    v.push_back(mk(0,0,0,16'h0000,0,16'h0000, 1,1,0,16'h1234,16'h0040));
    v.push_back(mk(0,0,0,16'h0000,1,16'hDEAD, 0,0,0,16'h1234,16'h0040)); // killed ack
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h1234,16'h0040));
    v.push_back(mk(0,0,0,16'h0000,1,16'h0BEE, 0,1,1,16'h0BEE,16'h0040));
    v.push_back(mk(0,1,1,16'h0100,0,16'h0000, 1,1,0,16'h0BEE,16'h0100)); // redirect in LOAD
    v.push_back(mk(0,0,0,16'h0000,1,16'h5555, 0,1,1,16'h5555,16'h0100));
    v.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,0,0,16'h5555,16'h0101));
    v.push_back(mk(0,0,0,16'h0000,1,16'hFFFF, 0,0,0,16'h5555,16'h0101)); // ack in IDLE ignored
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h5555,16'h0101));
    v.push_back(mk(0,0,1,16'h0200,0,16'h0000, 1,1,0,16'h5555,16'h0200));
    v.push_back(mk(0,0,1,16'h0300,0,16'h0000, 1,1,0,16'h5555,16'h0300)); // last redirect wins
    v.push_back(mk(0,0,0,16'h0000,1,16'hAAAA, 0,0,0,16'h5555,16'h0300));
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h5555,16'h0300)); // single discard only
    v.push_back(mk(0,0,1,16'h0400,1,16'h7777, 0,0,0,16'h5555,16'h0400)); // ack + redirect
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h5555,16'h0400));
    v.push_back(mk(0,1,0,16'h0000,1,16'h0001, 0,1,1,16'h0001,16'h0400)); // zero-wait stream
    v.push_back(mk(0,1,0,16'h0000,0,16'h0000, 1,1,0,16'h0001,16'h0401));
    v.push_back(mk(0,0,0,16'h0000,1,16'h0002, 0,1,1,16'h0002,16'h0401));
    v.push_back(mk(0,0,0,16'h0000,1,16'h9999, 0,0,0,16'h0002,16'h0402)); // ack in LOAD ignored

    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].rst, v[i].fe, v[i].pl, v[i].pla, v[i].ack, v[i].rdata);
      tick();
      chk($sformatf("vec%0d req", i),  {15'h0, mem_rd_req}, {15'h0, v[i].e_req});
      chk($sformatf("vec%0d busy", i), {15'h0, busy},       {15'h0, v[i].e_busy});
      chk($sformatf("vec%0d ir", i),   {15'h0, IR_load},    {15'h0, v[i].e_ir});
      chk($sformatf("vec%0d mdr", i),  MDR_data,            v[i].e_mdr);
      chk($sformatf("vec%0d pc", i),   pc_out,              v[i].e_pc);
      chk($sformatf("vec%0d addr", i), mem_addr,            v[i].e_pc);
    end

    // Two-wait-state memory with fetch_en held: words 1111/2222 at 0/1.
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    ir_cnt = 0; ir_first = -1; ir_second = -1; wcnt = 0; stable = 1'b1;
    req_addr = 16'h0;
    for (int c = 1; c <= 8; c++) begin
      logic ack_now;
      ack_now = mem_rd_req && (wcnt == 2);
      drive(1'b0, 1'b1, 1'b0, 16'h0, ack_now, (mem_addr == 16'h0) ? 16'h1111 : 16'h2222);
      if (mem_rd_req) begin
        if (wcnt == 0) req_addr = mem_addr;
        else if (mem_addr !== req_addr) stable = 1'b0;
        wcnt = ack_now ? 0 : wcnt + 1;
      end
      tick();
      if (IR_load) begin
        ir_cnt++;
        if (ir_first < 0) begin
          ir_first = c;
          chk("wait mdr0", MDR_data, 16'h1111);
        end else begin
          ir_second = c;
          chk("wait mdr1", MDR_data, 16'h2222);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    chk("wait ir count", 16'(ir_cnt), 16'd2);
    chk("wait ir spacing", 16'(ir_second - ir_first), 16'd4);
    chk("wait addr stable", {15'h0, stable}, 16'h1);
    chk("wait final pc", pc_out, 16'h0002);

    // Reset while a request is outstanding, then a late ack.
    drive(1'b0, 1'b1, 1'b1, 16'h0055, 1'b0, 16'h0);
    tick();
    chk("rst pre req", {15'h0, mem_rd_req}, 16'h1);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    chk("rst req", {15'h0, mem_rd_req}, 16'h0);
    chk("rst pc", pc_out, 16'h0000);
    chk("rst mdr", MDR_data, 16'h0000);
    chk("rst ir", {15'h0, IR_load}, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    tick();
    chk("late ack mdr", MDR_data, 16'h0000);
    chk("late ack busy", {15'h0, busy}, 16'h0);
    chk("late ack ir", {15'h0, IR_load}, 16'h0);
    chk("late ack pc", pc_out, 16'h0000);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
